// File: rtl/dff_ram_param.sv
// dff_ram_param: parametrised flop-based single-port RAM.
// Configurable width/depth/lane size, per-lane write masking, zero-fill sweep
// after reset or on clr_n request, out-of-range detection and read-valid strobe.
// Optional feature macro: DFF_RAM_WMASK_EN -- when defined, wmask gates each
// write lane; when undefined, wmask is ignored and writes update the full word.
`timescale 1ns/1ps

module dff_ram_param #(
    parameter int DATA_W = 72,
    parameter int DEPTH  = 4,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic                                   wr_n,
    input  logic                                   clr_n,
    input  logic [ADDR_W-1:0]                      address,
    input  logic [DATA_W-1:0]                      wdata,
    input  logic [(DATA_W+BYTE_W-1)/BYTE_W-1:0]    wmask,
    output logic [DATA_W-1:0]                      rdata,
    output logic                                   rvalid,
    output logic                                   busy,
    output logic                                   err
);

    localparam int LANES = (DATA_W + BYTE_W - 1) / BYTE_W;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                rvalid_reg, rvalid_next;
    logic                err_reg, err_next;

    // Storage: plain flops, deliberately not reset (the sweep zero-fills it).
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   lane_bits;    // bit-level write enable built from lanes
    logic [DATA_W-1:0]   rd_word;      // combinational read mux output
    logic                addr_ok;      // address falls inside the array
    logic                wr_go;        // an accepted in-range write this cycle
    logic [DEPTH-1:0]    word_clr;     // sweep clear select per word
    logic [DEPTH-1:0]    word_wr;      // write select per word

    // Widen by one bit so DEPTH itself is representable in the compare.
    assign addr_ok = ({1'b0, address} < (ADDR_W+1)'(DEPTH));

    // Expand lane enables into a per-bit mask; the last lane may be narrower.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int LO = gi * BYTE_W;
        localparam int HI = (LO + BYTE_W > DATA_W) ? DATA_W - 1 : LO + BYTE_W - 1;
        logic lane_en;
`ifdef DFF_RAM_WMASK_EN
        assign lane_en = wmask[gi];
`else
        assign lane_en = 1'b1;
`endif
        assign lane_bits[HI:LO] = {(HI - LO + 1){lane_en}};
    end

`ifndef DFF_RAM_WMASK_EN
    // Port kept for interface compatibility; its value has no effect here.
    logic unused_wmask;
    assign unused_wmask = ^wmask;
`endif

    // Per-word decode of sweep clears and accepted writes.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_sel
        assign word_clr[gi] = (state_reg == INIT) && (ptr_reg == ADDR_W'(gi));
        assign word_wr[gi]  = wr_go && (address == ADDR_W'(gi));
    end

    // Read mux: explicit compare per word so out-of-range codes never index.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (address == ADDR_W'(i)) begin
                rd_word = mem[i];
            end
        end
    end

    // Next-state, sweep pointer and registered-output logic.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        rdata_next  = rdata_reg;
        rvalid_next = 1'b0;
        err_next    = 1'b0;
        wr_go       = 1'b0;
        case (state_reg)
            INIT: begin
                // Accesses and clr_n are ignored while sweeping.
                if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (!clr_n) begin
                    // Clear request wins over any access in the same cycle.
                    state_next = INIT;
                    ptr_next   = '0;
                end else if (!en) begin
                    if (!addr_ok) begin
                        err_next = 1'b1;
                        if (wr_n) begin
                            rdata_next  = '0;
                            rvalid_next = 1'b1;
                        end
                    end else if (wr_n) begin
                        rdata_next  = rd_word;
                        rvalid_next = 1'b1;
                    end else begin
                        wr_go = 1'b1;
                    end
                end
            end
            default: begin
                state_next = INIT;
                ptr_next   = '0;
            end
        endcase
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= INIT;
            ptr_reg    <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            rdata_reg  <= rdata_next;
            rvalid_reg <= rvalid_next;
            err_reg    <= err_next;
        end
    end

    // Array update: sweep zero-fill, otherwise lane-merged write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (word_clr[i]) begin
                mem[i] <= '0;
            end else if (word_wr[i]) begin
                mem[i] <= (mem[i] & ~lane_bits) | (wdata & lane_bits);
            end
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign err    = err_reg;
    assign busy   = (state_reg == INIT);

endmodule
